// File: rtl/shift_multiplier.sv
// shift_multiplier: sequential unsigned shift-and-add multiplier.
// Produces the 2N-bit product of A and B, consuming one multiplier bit per
// rising clock edge. A new multiplication starts whenever rst_n is released.
// The result is final after N edges and then holds until the next reset.
//
// Optional feature macro: SHIFT_MULT_DONE_EN (adds the registered done port).
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset; release starts a multiply
//   A        - N-bit unsigned multiplicand, read live while running
//   B        - N-bit unsigned multiplier, read live while running
//   product  - 2N-bit accumulator (partial sums while running, A*B when done)
//   done     - (SHIFT_MULT_DONE_EN only) high once all N bits are consumed
module shift_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] product
`ifdef SHIFT_MULT_DONE_EN
  ,
  output logic           done
`endif
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  b_sh_c;
  logic          run_c;

  // Still consuming multiplier bits; cnt == N is the terminal (done) state.
  assign run_c  = (cnt_q < CW'(N));
  // Current multiplier bit lands in bit 0; avoids an over-wide bit select.
  assign b_sh_c = B >> cnt_q;

  // Next-state: conditionally add the shifted multiplicand, advance the index.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (run_c) begin
      if (b_sh_c[0]) begin
        acc_d = acc_q + (PW'(A) << cnt_q);
      end
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Accumulator and bit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign product = acc_q;

`ifdef SHIFT_MULT_DONE_EN
  logic done_q, done_d;

  // Rises on the same edge that the index reaches N.
  always_comb begin
    done_d = (cnt_d == CW'(N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_shift_multiplier.sv
// tb_shift_multiplier: directed and random checks of shift_multiplier (N=4).
// Inputs are driven on the falling edge; outputs are sampled 1ns after the
// rising edge.
module tb_shift_multiplier;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2 * N;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [PW-1:0] product;
`ifdef SHIFT_MULT_DONE_EN
  logic          done;
`endif

  int n_cmp;
  int n_err;

  shift_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .product (product)
`ifdef SHIFT_MULT_DONE_EN
    ,
    .done    (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_done(input string tag, input logic exp);
`ifdef SHIFT_MULT_DONE_EN
    n_cmp++;
    assert (done === exp) else begin
      n_err++;
      $error("FAIL %s: observed done=%b expected done=%b", tag, done, exp);
    end
`else
    if (tag.len() < 0 && exp) $display("%s", tag);
`endif
  endtask

  // Load operands, pulse reset between edges, release on a falling edge.
  task automatic start_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic edge_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    A = '0;
    B = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_product", product, 8'd0);
    chk_done("reset_done", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 15*15, then hold
    start_mul(4'd15, 4'd15);
    edge_n(5);
    chk("15x15", product, 8'd225);
    chk_done("15x15_done", 1'b1);
    edge_n(3);
    chk("15x15_hold", product, 8'd225);

    // 9*6 with partial sums after each edge
    start_mul(4'd9, 4'd6);
    edge_n(1); chk("9x6_e1", product, 8'd0);
    edge_n(1); chk("9x6_e2", product, 8'd18);
    edge_n(1); chk("9x6_e3", product, 8'd54);
    chk_done("9x6_e3_done", 1'b0);
    edge_n(1); chk("9x6_e4", product, 8'd54);
    chk_done("9x6_e4_done", 1'b1);

    // Zero operands
    start_mul(4'd0, 4'd13);
    for (int i = 1; i <= 5; i++) begin
      edge_n(1);
      chk($sformatf("0x13_e%0d", i), product, 8'd0);
    end
    start_mul(4'd11, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      edge_n(1);
      chk($sformatf("11x0_e%0d", i), product, 8'd0);
    end

    // Reset mid-run aborts, then a fresh run completes
    start_mul(4'd7, 4'd5);
    edge_n(2);
    chk("7x5_partial", product, 8'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("7x5_abort", product, 8'd0);
    chk_done("7x5_abort_done", 1'b0);
    edge_n(1);
    chk("7x5_in_reset", product, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n(3);
    chk("7x5_e3", product, 8'd35);
    chk_done("7x5_e3_done", 1'b0);
    edge_n(1);
    chk("7x5_e4", product, 8'd35);
    chk_done("7x5_e4_done", 1'b1);

    // Operand changes after completion are ignored
    start_mul(4'd3, 4'd4);
    edge_n(4);
    chk("3x4", product, 8'd12);
    chk_done("3x4_done", 1'b1);
    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    edge_n(4);
    chk("3x4_hold", product, 8'd12);
    chk_done("3x4_hold_done", 1'b1);

    // Random operand pairs
    for (int k = 0; k < 100; k++) begin
      ra = N'($urandom_range(0, 15));
      rb = N'($urandom_range(0, 15));
      start_mul(ra, rb);
      edge_n(5);
      chk($sformatf("rand%0d_%0dx%0d", k, ra, rb), product, PW'(ra) * PW'(rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
